// File: rtl/sub_mag.sv
// Chunked unsigned subtractor: diff = in1 - in2 over NCHUNK borrow-chained cycles,
// plus a second chunked negate pass giving |in1 - in2| and swap when the result is negative.
module sub_mag #(
  parameter int WIDTH = 74,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] mag,
  output logic             swap
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d, mag_q, mag_d;
  logic             swap_q, swap_d, borrow_q, borrow_d;

  logic [31:0]      sh;
  logic [CHUNK-1:0] x_sl, y_sl;
  logic [CHUNK:0]   res;
  logic [WIDTH-1:0] slice_mask, res_w, diff_ins, mag_ins;

  // One shared slice subtractor: a-b in SUB, 0-diff in NEG. Zero-extended
  // slices make bit CHUNK the borrow out of the top real bit, even for the
  // narrower last chunk.
  always_comb begin
    sh = 32'(k_q) * 32'(CHUNK);
    if (state_q == NEG) begin
      x_sl = '0;
      y_sl = CHUNK'(diff_q >> sh);
    end else begin
      x_sl = CHUNK'(a_q >> sh);
      y_sl = CHUNK'(b_q >> sh);
    end
    res        = {1'b0, x_sl} - {1'b0, y_sl} - (CHUNK+1)'(borrow_q);
    slice_mask = WIDTH'({CHUNK{1'b1}}) << sh;
    res_w      = WIDTH'(res[CHUNK-1:0]) << sh;
    diff_ins   = (diff_q & ~slice_mask) | res_w;
    mag_ins    = (mag_q & ~slice_mask) | res_w;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    mag_d    = mag_q;
    swap_d   = swap_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = in1;
          b_d      = in2;
          k_d      = '0;
          borrow_d = 1'b0;
          swap_d   = 1'b0;
          state_d  = SUB;
        end
      end
      SUB: begin
        diff_d   = diff_ins;
        borrow_d = res[CHUNK];
        if (k_q == KLAST) begin
          k_d    = '0;
          swap_d = res[CHUNK];
          if (res[CHUNK]) begin
            borrow_d = 1'b0;
            state_d  = NEG;
          end else begin
            mag_d   = diff_ins;
            state_d = DONE;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      NEG: begin
        mag_d    = mag_ins;
        borrow_d = res[CHUNK];
        if (k_q == KLAST) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      mag_q    <= '0;
      swap_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      mag_q    <= mag_d;
      swap_q   <= swap_d;
      borrow_q <= borrow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign mag       = mag_q;
  assign swap      = swap_q;

endmodule

// File: tb/tb_sub_mag.sv
// Randomized scoreboard bench for sub_mag: driver pushes model results, monitor checks on out_valid.
module tb_sub_mag;
  localparam int W   = 74;
  localparam int NCH = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         or_man = 1'b1;
  logic         rr = 1'b1;
  logic         rand_rdy = 1'b0;
  logic         out_ready;
  logic         in_ready, out_valid, swap;
  logic [W-1:0] diff, mag;

  assign out_ready = rand_rdy ? rr : or_man;

  sub_mag #(.WIDTH(W), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .mag(mag), .swap(swap)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] m;
    logic         s;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  logic ov_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rand_rdy) #1 rr = ($urandom_range(0, 3) != 0);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction and comparison
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    e.d   = a - b;
    e.s   = (a < b);
    e.m   = e.s ? (b - a) : (a - b);
    e.acc = acc;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit done;
    done = 0;
    @(posedge clk) #1;
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(a, b, cyc + 1));
        @(posedge clk) #1;
        in_valid = 1'b0;
        in1 = {$urandom, $urandom, $urandom};
        in2 = {$urandom, $urandom, $urandom};
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never seen");
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", W'(q.size()), '0);
    @(posedge clk) #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_out_valid"}, W'(out_valid), '0);
    chk({tag, "_diff"}, diff, '0);
    chk({tag, "_mag"}, mag, '0);
    chk({tag, "_swap"}, W'(swap), '0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!ov_prev) first_cyc = cyc;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: out_valid=1 with no pending op at cycle %0d", cyc);
      end else begin
        chk("diff", diff, q[0].d);
        chk("mag", mag, q[0].m);
        chk("swap", W'(swap), W'(q[0].s));
        chk("in_ready_in_done", W'(in_ready), '0);
        if (!ov_prev)
          chk("latency", W'(first_cyc - q[0].acc), W'(q[0].s ? 2 * NCH : NCH));
        if (out_ready) void'(q.pop_front());
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    logic [W-1:0] t, a, b;
    bit           seen;
    #1 rst = 1'b1;
    #1 chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases, issued back to back
    send(W'(100), W'(58));
    send(W'(5), W'(7));
    t = '0;
    t[64] = 1'b1;
    send(t, W'(1));
    send('0, '1);
    send(W'(123), W'(123));
    drain();

    // Backpressure in DONE
    or_man = 1'b0;
    send(W'(1000), W'(1));
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("bp_out_valid_seen", W'(seen), W'(1));
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid_held", W'(out_valid), W'(1));
    end
    @(posedge clk) #1;
    or_man = 1'b1;
    @(negedge clk);
    @(posedge clk) #1;
    chk("bp_idle_in_ready", W'(in_ready), W'(1));
    chk("bp_idle_out_valid", W'(out_valid), '0);
    send(W'(77), W'(78));
    drain();

    // Reset during the third SUB cycle
    send(W'(1000), W'(3));
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst = 1'b1;
    #1 chk_reset_vals("midrst");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_release_in_ready", W'(in_ready), W'(1));
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("midrst_no_stale_valid", W'(seen), '0);
    send(W'(9), W'(4));
    drain();

    // Random operands with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a + W'($urandom_range(0, 3)) - W'(1);
        default: b = {$urandom, $urandom, $urandom};
      endcase
      send(a, b);
    end
    drain();
    rand_rdy = 1'b0;
    or_man = 1'b1;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
